// File: rtl/fetch_seq_if.sv
// Fetch-sequencer bus: bundles the instruction-memory handshake, the hazard
// and redirect requests coming from ID/EX, and the control lines sent to the
// fetch datapath and the IF/ID and ID/EX pipeline latches.
//   master : the sequencer (drives imem_req, pc_stall, pc_src, jump_sel,
//            redirect_target, ifid_flush, idex_flush, fetch_valid)
//   slave  : the surrounding pipeline / memory (drives imem_ready,
//            hazard_stall, branch_taken, jump, jump_target, branch_target)
interface fetch_seq_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic          imem_ready;
  logic          hazard_stall;
  logic          branch_taken;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] branch_target;
  logic          pc_stall;
  logic          pc_src;
  logic          jump_sel;
  logic [AW-1:0] redirect_target;
  logic          ifid_flush;
  logic          idex_flush;
  logic          fetch_valid;

  modport master (
    input  imem_ready, hazard_stall, branch_taken, jump,
    input  jump_target, branch_target,
    output imem_req, pc_stall, pc_src, jump_sel, redirect_target,
    output ifid_flush, idex_flush, fetch_valid
  );

  modport slave (
    output imem_ready, hazard_stall, branch_taken, jump,
    output jump_target, branch_target,
    input  imem_req, pc_stall, pc_src, jump_sel, redirect_target,
    input  ifid_flush, idex_flush, fetch_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control. Arbitrates EX branch redirects
// (oldest), ID jumps and load-use stalls, and holds a redirect that arrives
// while an instruction-memory fetch is still outstanding until it completes.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   bus          fetch_seq_if.master (handshake, redirect inputs, fetch controls)
//   stall_cnt    cycles spent with pc_stall=1     (FETCH_SEQ_PERF_EN only)
//   redirect_cnt redirects applied to fetch       (FETCH_SEQ_PERF_EN only)
// Optional feature macro: FETCH_SEQ_PERF_EN adds the saturating perf counters.
module fetch_sequencer #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  fetch_seq_if.master    bus
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  redirect_cnt
`endif
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PEND = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pend_target_q, pend_target_d;
  logic          pend_valid_q, pend_valid_d;

  // imem_req depends on state only, so there is no path from imem_ready.
  always_comb begin
    state_d             = state_q;
    pend_target_d       = pend_target_q;
    pend_valid_d        = pend_valid_q;
    bus.imem_req        = 1'b0;
    bus.pc_stall        = 1'b0;
    bus.pc_src          = 1'b0;
    bus.jump_sel        = 1'b0;
    bus.redirect_target = '0;
    bus.ifid_flush      = 1'b0;
    bus.idex_flush      = 1'b0;
    bus.fetch_valid     = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        bus.imem_req = 1'b1;
        if (bus.branch_taken) begin
          // A same-cycle jump is younger than the branch and is dropped.
          if (bus.imem_ready) begin
            bus.pc_src          = 1'b1;
            bus.redirect_target = bus.branch_target;
            bus.ifid_flush      = 1'b1;
            bus.idex_flush      = 1'b1;
          end else begin
            pend_target_d  = bus.branch_target;
            pend_valid_d   = 1'b1;
            state_d        = PEND;
            bus.pc_stall   = 1'b1;
            bus.idex_flush = 1'b1;
          end
        end else if (bus.jump) begin
          if (bus.imem_ready) begin
            bus.jump_sel        = 1'b1;
            bus.redirect_target = bus.jump_target;
            bus.ifid_flush      = 1'b1;
          end else begin
            pend_target_d = bus.jump_target;
            pend_valid_d  = 1'b1;
            state_d       = PEND;
            bus.pc_stall  = 1'b1;
          end
        end else if (bus.hazard_stall) begin
          bus.pc_stall = 1'b1;
        end else begin
          bus.pc_stall    = ~bus.imem_ready;
          bus.fetch_valid = bus.imem_ready;
        end
      end

      PEND: begin
        bus.imem_req = 1'b1;
        bus.pc_stall = 1'b1;
        if (!pend_valid_q) begin
          // Nothing held: fall back to normal sequencing.
          state_d = RUN;
        end else if (bus.imem_ready && bus.branch_taken) begin
          // Live branch is older than anything held; use the adder path.
          bus.pc_stall        = 1'b0;
          bus.pc_src          = 1'b1;
          bus.redirect_target = bus.branch_target;
          bus.ifid_flush      = 1'b1;
          bus.idex_flush      = 1'b1;
          pend_valid_d        = 1'b0;
          state_d             = RUN;
        end else if (bus.imem_ready) begin
          bus.pc_stall        = 1'b0;
          bus.jump_sel        = 1'b1;
          bus.redirect_target = pend_target_q;
          bus.ifid_flush      = 1'b1;
          pend_valid_d        = 1'b0;
          state_d             = RUN;
        end else if (bus.branch_taken) begin
          // Branch overrides a held jump; jumps and stalls here are wrong-path.
          pend_target_d  = bus.branch_target;
          bus.idex_flush = 1'b1;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] redirect_cnt_q, redirect_cnt_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // pc_stall is always 0 in BOOT, so no state qualification is needed.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (bus.pc_stall)                stall_cnt_d    = sat_inc(stall_cnt_q);
    if (bus.pc_src || bus.jump_sel)  redirect_cnt_d = sat_inc(redirect_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the instruction-fetch stage: it drives the PC stall, branch-select and jump-select inputs of the fetch datapath and the IF/ID and ID/EX flush lines. It arbitrates between EX-stage branch redirects, ID-stage jumps and load-use stalls. It also tracks a ready-handshaked instruction memory, latching any redirect that arrives while a fetch is outstanding. It sits between the hazard unit, the ID/EX stages and the fetch stage.

## Interface
Parameters:
- AW, 32, address width of targets and PC.
- CW, 16, perf counter width (used only with FETCH_SEQ_PERF_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on clk rising edge.
- imem_req  out  1  fetch request to instruction memory.
- imem_ready  in  1  fetch completes this cycle.
- hazard_stall  in  1  load-use stall from the hazard unit.
- branch_taken  in  1  EX-stage branch resolved taken; one-cycle pulse.
- jump  in  1  ID-stage jump decoded; one-cycle pulse.
- jump_target  in  AW  jump destination, valid with jump.
- branch_target  in  AW  branch destination; the same value as the ALU-adder result, valid with branch_taken.
- pc_stall  out  1  hold PC; drives the fetch-stage hazardStall input.
- pc_src  out  1  select the branch-adder path in fetch.
- jump_sel  out  1  select redirect_target in fetch.
- redirect_target  out  AW  value for the fetch jump-mux input.
- ifid_flush  out  1  squash the IF/ID contents at this edge.
- idex_flush  out  1  squash the ID/EX contents at this edge.
- fetch_valid  out  1  the IF/ID latch takes a valid instruction at this edge.
- stall_cnt  out  CW  cycles with pc_stall=1 (FETCH_SEQ_PERF_EN only).
- redirect_cnt  out  CW  redirects applied (FETCH_SEQ_PERF_EN only).

## Operation
- State register has three states: BOOT, RUN, PEND. Pending registers are pend_target (AW bits) and pend_valid.
- BOOT (entered while reset=0):
  - All outputs are 0, including redirect_target.
  - BOOT moves to RUN on the first edge after reset=1.
- RUN: imem_req=1. Priority is branch_taken > jump > hazard_stall > sequential.
  - branch_taken with imem_ready=1: pc_src=1, jump_sel=0, pc_stall=0, ifid_flush=1, idex_flush=1, fetch_valid=0. Any same-cycle jump is dropped because it is a younger instruction.
  - jump with imem_ready=1 (no branch): jump_sel=1, redirect_target=jump_target, pc_stall=0, ifid_flush=1, fetch_valid=0.
  - Redirect with imem_ready=0:
    - Latch the target into pend_target, set pend_valid, and go to PEND.
    - pc_stall=1.
    - idex_flush=1 if the redirect is a branch.
  - hazard_stall (no redirect): pc_stall=1, fetch_valid=0, no flush.
  - Sequential case: pc_stall=~imem_ready, fetch_valid=imem_ready.
- PEND: imem_req=1, pc_stall=1 until the redirect is applied.
  - A branch_taken in PEND overwrites pend_target and asserts idex_flush. The branch is older than a pending jump.
  - A jump in PEND is ignored because it is wrong-path.
  - hazard_stall is ignored in PEND.
  - On imem_ready=1: jump_sel=1, redirect_target=pend_target, pc_stall=0, ifid_flush=1, fetch_valid=0. Clear pend_valid and go to RUN.
  - If branch_taken and imem_ready arrive in the same cycle, the live branch target is used via pc_src=1.
- Outputs are Mealy: combinational from state, the pending registers and the current inputs. Default values are pc_src=0, jump_sel=0, redirect_target=0 whenever no redirect is applied.
- reset=0 in any state: at the edge, go to BOOT, clear pend_valid and pend_target, and clear the counters. The in-flight pending redirect is discarded.

## Timing
- A live redirect with imem_ready=1 is applied in the same cycle; the PC shows the target after the next edge.
- A latched redirect is applied in the first cycle with imem_ready=1 after it was latched. The minimum is 1 cycle after arrival.
- ifid_flush and idex_flush are single-cycle per event and never asserted in BOOT.
- pc_src and jump_sel are never both 1.
- fetch_valid=1 implies pc_stall=0.
- No combinational path from imem_ready to imem_req.

## Configuration
- FETCH_SEQ_PERF_EN defined:
  - stall_cnt increments on every cycle with pc_stall=1 in RUN or PEND.
  - redirect_cnt increments on every cycle with pc_src|jump_sel.
  - Both counters are CW-bit, saturate at all-ones and reset to 0.
- FETCH_SEQ_PERF_EN undefined: both ports and both counters are absent; no other behaviour changes.

## Test plan
- Reset sequence: hold reset=0 for 3 cycles. All outputs stay 0, then RUN starts. With imem_ready=1, fetch_valid=1 and pc_stall=0 on the first RUN cycle.
- Live branch: imem_ready=1, branch_taken=1, branch_target=0x40, plus jump=1 with jump_target=0x80 in the same cycle. Required: pc_src=1, jump_sel=0, ifid_flush=1, idex_flush=1; the jump is dropped and the next PC is 0x40.
- Latched jump: imem_ready=0, jump=1, jump_target=0x100. Required: PEND and pc_stall=1. Two cycles later imem_ready=1 gives jump_sel=1, redirect_target=0x100, ifid_flush=1, then RUN.
- Overwrite in PEND: jump to 0x100 is latched, then branch_taken to 0x200 arrives while imem_ready=0. Required: idex_flush=1 on the branch cycle; when imem_ready=1, redirect_target=0x200.
- Load-use stall: hazard_stall=1 for 2 cycles with imem_ready=1. Required: pc_stall=1 and fetch_valid=0 for exactly 2 cycles, no flushes. With FETCH_SEQ_PERF_EN, stall_cnt increases by 2.
- Reset mid-PEND: latch a redirect, then drive reset=0 for one cycle. Required: BOOT with pend_valid cleared; a later imem_ready=1 produces no jump_sel.
